// File: rtl/dmem_responder_pkg.sv
// dmem_responder_pkg: shared LSU/dcache widths, access-size codes and load extract/extend helpers
package dmem_responder_pkg;

    localparam int XLEN               = 64;
    localparam int VIRTUAL_ADDR_LEN   = 39;
    localparam int LSU_LSQ_SIZE_WIDTH = 3;

    localparam logic [1:0] LS_SIZE_B = 2'd0;
    localparam logic [1:0] LS_SIZE_H = 2'd1;
    localparam logic [1:0] LS_SIZE_W = 2'd2;
    localparam logic [1:0] LS_SIZE_D = 2'd3;

    typedef struct packed {
        logic [LSU_LSQ_SIZE_WIDTH-1:0] tag;
        logic [XLEN-1:0]               data;
    } resp_t;

    // Misaligned offsets are aligned down to the access size
    function automatic logic [2:0] align_off(input logic [2:0] off, input logic [1:0] size);
        return size == LS_SIZE_D ? 3'd0 :
               size == LS_SIZE_W ? {off[2], 2'b00} :
               size == LS_SIZE_H ? {off[2:1], 1'b0} : off;
    endfunction

    // Byte-lane mask of an access at lane 0
    function automatic logic [7:0] size_mask(input logic [1:0] size);
        return size == LS_SIZE_D ? 8'hff :
               size == LS_SIZE_W ? 8'h0f :
               size == LS_SIZE_H ? 8'h03 : 8'h01;
    endfunction

    // Shift the addressed bytes to the LSB, then sign- or zero-extend
    function automatic logic [XLEN-1:0] load_extend(input logic [XLEN-1:0] dw, input logic [2:0] off,
                                                    input logic [1:0] size, input logic sgn);
        logic [XLEN-1:0] s;
        s = dw >> {off, 3'b000};
        return size == LS_SIZE_B ? {{56{sgn & s[7]}}, s[7:0]} :
               size == LS_SIZE_H ? {{48{sgn & s[15]}}, s[15:0]} :
               size == LS_SIZE_W ? {{32{sgn & s[31]}}, s[31:0]} : s;
    endfunction

endpackage

// File: rtl/dmem_resp_fifo.sv
// dmem_resp_fifo: show-ahead FIFO of {tag, data} responses with a synchronous flush-clear
module dmem_resp_fifo
    import dmem_responder_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic  clk,
    input  logic  rstn,
    input  logic  flush,
    input  logic  push,
    input  resp_t din,
    input  logic  pop,
    output logic  empty,
    output resp_t dout
);

    localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    resp_t         mem [DEPTH];
    logic [PW-1:0] rp;
    logic [PW-1:0] wp;
    logic [CW-1:0] cnt;
    logic          do_pop;

    assign empty  = cnt == '0;
    assign do_pop = pop & ~empty;
    assign dout   = mem[rp];

    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        return p == PW'(DEPTH - 1) ? '0 : p + 1'b1;
    endfunction

    // Pointers and fill count; flush drops every entry
    always_ff @(posedge clk or posedge rstn)
        if (rstn) begin
            rp  <= '0;
            wp  <= '0;
            cnt <= '0;
        end else if (flush) begin
            rp  <= '0;
            wp  <= '0;
            cnt <= '0;
        end else begin
            if (push) wp <= nxt(wp);
            if (do_pop) rp <= nxt(rp);
            cnt <= cnt + CW'(push) - CW'(do_pop);
        end

    // Entry storage needs no reset: the fill count qualifies it
    always_ff @(posedge clk)
        if (push) mem[wp] <= din;

endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: LSU-facing data memory that answers loads/stores in order after a fixed latency
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int MEM_DEPTH        = 512,
    parameter int LATENCY          = 2,
    parameter int RESP_QUEUE_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rstn,
    input  logic                          flush,
    input  logic                          req_valid_i,
    input  logic                          req_opcode_i,
    input  logic                          req_sign_i,
    input  logic [LSU_LSQ_SIZE_WIDTH-1:0] req_lsq_index_i,
    input  logic [1:0]                    req_size_i,
    input  logic [VIRTUAL_ADDR_LEN-1:0]   req_addr_i,
    input  logic [XLEN-1:0]               req_data_i,
    output logic                          req_ready_o,
    output logic                          resp_valid_o,
    output logic [LSU_LSQ_SIZE_WIDTH-1:0] resp_lsq_index_o,
    output logic [XLEN-1:0]               resp_data_o,
    input  logic                          resp_ready_i
);

    localparam int AW = $clog2(MEM_DEPTH);
    localparam int OW = $clog2(RESP_QUEUE_DEPTH + 1);

    logic [XLEN-1:0] mem [MEM_DEPTH];
    logic [OW-1:0]   occ;
    logic [AW-1:0]   idx;
    logic [2:0]      off;
    logic [7:0]      wmask;
    logic [XLEN-1:0] wdata;
    logic            acc;
    logic            ret;
    logic            push;
    logic            fifo_empty;
    resp_t           new_ent;
    resp_t           push_ent;
    resp_t           head;
    logic            unused_addr;

    assign idx         = req_addr_i[AW+2:3];
    assign off         = align_off(req_addr_i[2:0], req_size_i);
    assign wmask       = size_mask(req_size_i) << off;
    assign wdata       = req_data_i << {off, 3'b000};
    assign acc         = req_valid_i & req_ready_o;
    assign ret         = resp_valid_o & resp_ready_i;
    assign req_ready_o = (occ < OW'(RESP_QUEUE_DEPTH)) & ~flush;
    assign new_ent     = '{tag: req_lsq_index_i,
                           data: req_opcode_i ? '0 : load_extend(mem[idx], off, req_size_i, req_sign_i)};
    assign resp_valid_o     = ~fifo_empty;
    assign resp_lsq_index_o = fifo_empty ? '0 : head.tag;
    assign resp_data_o      = fifo_empty ? '0 : head.data;
    assign unused_addr      = ^req_addr_i[VIRTUAL_ADDR_LEN-1:AW+3];

    // Byte-masked store into the array on the acceptance edge
    always_ff @(posedge clk)
        if (acc & req_opcode_i)
            for (int b = 0; b < 8; b++)
                if (wmask[b]) mem[idx][8*b +: 8] <= wdata[8*b +: 8];

    // Outstanding count spans both the latency pipe and the response queue
    always_ff @(posedge clk or posedge rstn)
        if (rstn) occ <= '0;
        else if (flush) occ <= '0;
        else occ <= occ + OW'(acc) - OW'(ret);

    // LATENCY-1 pipe stages ahead of the queue; the queue head is visible one cycle after its push
    generate
        if (LATENCY == 1) begin : g_direct
            assign push     = acc;
            assign push_ent = new_ent;
        end else begin : g_pipe
            logic [LATENCY-2:0] pv;
            resp_t              pe [LATENCY-1];
            // Stage valid bits; flush empties the pipe
            always_ff @(posedge clk or posedge rstn)
                if (rstn) pv <= '0;
                else if (flush) pv <= '0;
                else begin
                    pv[0] <= acc;
                    for (int i = 1; i < LATENCY - 1; i++) pv[i] <= pv[i-1];
                end
            // Stage payloads, qualified by the valid bits
            always_ff @(posedge clk) begin
                pe[0] <= new_ent;
                for (int i = 1; i < LATENCY - 1; i++) pe[i] <= pe[i-1];
            end
            assign push     = pv[LATENCY-2] & ~flush;
            assign push_ent = pe[LATENCY-2];
        end
    endgenerate

    dmem_resp_fifo #(.DEPTH(RESP_QUEUE_DEPTH)) u_fifo (
        .clk   (clk),
        .rstn  (rstn),
        .flush (flush),
        .push  (push),
        .din   (push_ent),
        .pop   (ret),
        .empty (fifo_empty),
        .dout  (head)
    );

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Memory-side end of the LSU↔dcache request/response interface. It accepts one load or store per cycle from the LSU over the `req_*` valid/ready channel and performs it against an internal doubleword-organised data array. It returns an in-order response tagged with the requester's LSQ index over the `resp_*` valid/ready channel, after a fixed programmable latency. It serves as the dcache stand-in for core bring-up and as the reference responder for blocking and non-blocking LSU verification.

## Interface
- `XLEN`, 64: data width.
- `VIRTUAL_ADDR_LEN`, 39: request address width.
- `LSU_LSQ_SIZE_WIDTH`, 3: LSQ tag width.
- `MEM_DEPTH`, 512: array depth in XLEN-bit doublewords; power of two.
- `LATENCY`, 2: minimum cycles from request acceptance to response valid; must be ≥1.
- `RESP_QUEUE_DEPTH`, 4: maximum outstanding accepted-but-unreturned requests; must be ≥1.

Ports:
- `clk` input 1: single clock, rising edge.
- `rstn` input 1: asynchronous reset, active-high (asserted = 1).
- `flush` input 1: synchronous; discards all outstanding responses.
- `req_valid_i` input 1: request valid.
- `req_opcode_i` input 1: 0 = load, 1 = store.
- `req_sign_i` input 1: load sign-extend when 1.
- `req_lsq_index_i` input `LSU_LSQ_SIZE_WIDTH`: tag returned with the response.
- `req_size_i` input 2: 0 = byte, 1 = half, 2 = word, 3 = double.
- `req_addr_i` input `VIRTUAL_ADDR_LEN`: byte address.
- `req_data_i` input `XLEN`: store data, LSB-aligned.
- `req_ready_o` output 1: can accept a request this cycle.
- `resp_valid_o` output 1: response valid.
- `resp_lsq_index_o` output `LSU_LSQ_SIZE_WIDTH`: tag of the request.
- `resp_data_o` output `XLEN`: extended load data; 0 for stores.
- `resp_ready_i` input 1: LSU accepts the response.

## Operation
- Handshakes:
  - A request is accepted on a rising edge with `req_valid_i & req_ready_o`.
  - A response retires on a rising edge with `resp_valid_o & resp_ready_i`.
- Outstanding count `occ` covers both the latency pipe and the response queue.
  - `occ` increments on acceptance and decrements on retire; both in the same cycle leave it unchanged.
  - `req_ready_o = (occ < RESP_QUEUE_DEPTH) & ~flush`.
- Address decoding:
  - Array index = `req_addr_i[$clog2(MEM_DEPTH)+2:3]`; upper address bits are ignored, so addresses wrap modulo `MEM_DEPTH*8`.
  - Byte offset = `req_addr_i[2:0]` with the low bits forced to size alignment: half clears bit 0, word clears [1:0], double clears [2:0]. Misaligned requests are therefore silently aligned down.
- Store: the array write happens on the acceptance edge, under a byte mask of size width at the offset. `req_data_i[8*N-1:0]` is placed at lane `offset`. A store always produces a response with `resp_data_o = 0`.
- Load: the array read is taken at acceptance and reflects every store accepted on an earlier edge. The selected bytes are shifted to the LSB, then sign-extended if `req_sign_i`, else zero-extended.
- Responses return strictly in acceptance order.
- Flush:
  - All pipe and queue entries are discarded, `occ` is cleared, and no request is accepted that cycle.
  - Stores already accepted remain written.
- Array contents are not reset.

## Timing
- Reset values:
  - `resp_valid_o = 0`, `resp_lsq_index_o = 0`, `resp_data_o = 0`.
  - `occ = 0`, so `req_ready_o = 1` once `flush` is low.
- Request accepted at edge k with an empty queue: `resp_valid_o = 1` during the cycle after edge k+`LATENCY`-1. With `LATENCY = 1`, the response is valid in the cycle immediately after acceptance.
- Backpressure:
  - With `resp_ready_i = 0`, the response holds stable (valid, tag, data) until retired.
  - Later entries keep maturing behind it.
  - Once retired, the next mature entry is presented the following cycle with no bubble.
- Full: at `occ == RESP_QUEUE_DEPTH`, `req_ready_o = 0`. A retire in that cycle raises `req_ready_o` the next cycle; it is not combinational from `resp_ready_i`.
- Throughput: sustained 1 request/cycle when `RESP_QUEUE_DEPTH ≥ LATENCY` and `resp_ready_i` is held high.
- Flush at edge k: `resp_valid_o = 0` from cycle k+1; a request presented in the flush cycle is not accepted.
- Reset asserted mid-operation: all outputs go to their reset values immediately (asynchronously); outstanding responses are lost.

## Structure
- `XLEN`, `VIRTUAL_ADDR_LEN`, `LSU_LSQ_SIZE_WIDTH` and the size encodings (`LS_SIZE_B/H/W/D`) come from the shared `params.vh`.
- The load extract/extend function belongs in the same shared header so the LSU model can reuse it.
- One sub-module: `dmem_resp_fifo`, a synchronous FIFO of {tag, data} entries with a flush-clear input. The latency pipe is a shift register of {valid, tag, data} inside the top block.

## Test plan
- Store double 0x1122334455667788 to 0x40, tag 1, then load double signed from 0x40, tag 2 → responses tag 1 with data 0, then tag 2 with 0x1122334455667788, each `LATENCY` cycles after its acceptance.
- Store byte 0x80 to 0x43, then load byte signed from 0x43 → 0xFFFFFFFFFFFFFF80. Load unsigned from 0x43 → 0x80. Load half unsigned from 0x43 (aligned to 0x42) → 0x8000 | byte[0x42].
- `resp_ready_i = 0`, issue 4 loads (tags 0–3) → the 4th acceptance makes `req_ready_o` drop; the 5th is not accepted. Raise `resp_ready_i` → tags 0,1,2,3 retire on consecutive cycles and `req_ready_o` returns one cycle after the first retire.
- `LATENCY = 2`, back-to-back loads every cycle with `resp_ready_i = 1` → one response per cycle, in order, no bubbles.
- Three loads outstanding, pulse `flush` → `resp_valid_o = 0` next cycle, `occ = 0`, and a store accepted before the flush is visible to a later load.
- Assert `rstn` while 2 responses are pending → `resp_valid_o` falls without waiting for an edge. After release, `req_ready_o = 1` and address 0x40 + `MEM_DEPTH*8` aliases 0x40.
